// File: rtl/koopa_anim_pkg.sv
// Shared constants and tables for the koopa sprite front end.
// The ROM holds 14 frames of 23x30 pixels (690 words each, 9660 words total).
// Per-animation tables are indexed by anim_e. The frame base table is indexed
// by the absolute frame number.
package koopa_anim_pkg;

  typedef enum logic [2:0] {
    ANIM_IDLE   = 3'd0,
    ANIM_WALK   = 3'd1,
    ANIM_JUMP   = 3'd2,
    ANIM_ATTACK = 3'd3,
    ANIM_HURT   = 3'd4
  } anim_e;

  localparam int SPRITE_W     = 23;
  localparam int SPRITE_H     = 30;
  localparam int FRAMES_TOTAL = 14;

  localparam logic [3:0] FIRST_FRAME [5] = '{4'd0, 4'd2, 4'd6, 4'd8,  4'd12};
  localparam logic [3:0] LAST_FRAME  [5] = '{4'd1, 4'd5, 4'd7, 4'd11, 4'd13};
  localparam logic       LOOPS       [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic       ONESHOT     [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  // k*690 word offset of each frame in the ROM
  localparam logic [13:0] FRAME_BASE [FRAMES_TOTAL] = '{
    14'd0,    14'd690,  14'd1380, 14'd2070, 14'd2760, 14'd3450, 14'd4140,
    14'd4830, 14'd5520, 14'd6210, 14'd6900, 14'd7590, 14'd8280, 14'd8970
  };

  // Request codes 5..7 are treated as IDLE
  function automatic anim_e to_anim(input logic [2:0] req);
    return (req > 3'd4) ? ANIM_IDLE : anim_e'(req);
  endfunction

endpackage

// File: rtl/koopa_anim_fsm.sv
// Per-fighter animation state machine.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   frame_tick   one pulse per video frame; drives the hold counter
//   anim_req     requested animation (5..7 = IDLE)
//   anim_frame   current absolute frame index 0..13
//   anim_done    one-cycle pulse when ATTACK or HURT finishes
module koopa_anim_fsm #(
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [2:0] anim_req,
  output logic [3:0] anim_frame,
  output logic       anim_done
);
  import koopa_anim_pkg::*;

  localparam int HOLD_W = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAMES_PER_STEP - 1);

  anim_e             state_q, state_d, req_a;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        frame_d;
  logic              done_d;
  logic              switch_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ANIM_IDLE;
      hold_q     <= '0;
      anim_frame <= 4'd0;
      anim_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      anim_frame <= frame_d;
      anim_done  <= done_d;
    end
  end

  always_comb begin
    req_a     = to_anim(anim_req);
    state_d   = state_q;
    hold_d    = hold_q;
    frame_d   = anim_frame;
    done_d    = 1'b0;
    switch_ok = 1'b0;
    // ATTACK only yields to HURT; HURT runs to completion uninterrupted
    case (state_q)
      ANIM_ATTACK: switch_ok = (req_a == ANIM_HURT);
      ANIM_HURT:   switch_ok = 1'b0;
      default:     switch_ok = (req_a != state_q);
    endcase
    // A request takes priority over a coincident frame advance
    if (switch_ok) begin
      state_d = req_a;
      frame_d = FIRST_FRAME[req_a];
      hold_d  = '0;
    end else if (frame_tick) begin
      if (hold_q != HOLD_LAST) begin
        hold_d = hold_q + 1'b1;
      end else begin
        hold_d = '0;
        if (anim_frame != LAST_FRAME[state_q]) begin
          frame_d = anim_frame + 4'd1;
        end else if (ONESHOT[state_q]) begin
          state_d = ANIM_IDLE;
          frame_d = FIRST_FRAME[ANIM_IDLE];
          done_d  = 1'b1;
        end else if (LOOPS[state_q]) begin
          frame_d = FIRST_FRAME[state_q];
        end
        // JUMP neither loops nor finishes: it parks on its last frame
      end
    end
  end

endmodule

// File: rtl/koopa_sprite_addr_gen.sv
// Koopa sprite address/animation front end.
// Maps the beam position onto the sprite box, produces the ROM word address,
// runs the animation FSM and delays the hit flag to line up with ROM rgb.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_tick            start-of-vblank pulse; latches the shadow registers
//   pixel_valid           beam in visible area
//   draw_x, draw_y        beam position
//   sprite_x, sprite_y    sprite top-left corner
//   facing_left           mirror horizontally
//   player_in             palette select
//   anim_req              requested animation
//   rom_addr              ROM word address (one cycle after the beam sample)
//   rom_player            latched palette select
//   sprite_hit            beam inside sprite box (two cycles after the sample)
//   anim_frame, anim_done animation status
module koopa_sprite_addr_gen #(
  parameter int SPRITE_W        = 23,
  parameter int SPRITE_H        = 30,
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        pixel_valid,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        facing_left,
  input  logic        player_in,
  input  logic [2:0]  anim_req,
  output logic [13:0] rom_addr,
  output logic        rom_player,
  output logic        sprite_hit,
  output logic [3:0]  anim_frame,
  output logic        anim_done
);
  import koopa_anim_pkg::*;

  // Row offset dy*23 as shift-add; the ROM row pitch is fixed at 23 words
  function automatic logic [9:0] mul23(input logic [4:0] d);
    logic [9:0] w;
    w = {5'b0, d};
    return (w << 4) + (w << 2) + (w << 1) + w;
  endfunction

  logic [9:0]  sx_sh, sy_sh;
  logic        face_sh, player_sh;
  logic [3:0]  frame_sh;
  logic [10:0] dx, dy;
  logic        hit_p0, hit_p1;
  logic [4:0]  col_p0;
  logic [13:0] addr_p0;

  koopa_anim_fsm #(.FRAMES_PER_STEP(FRAMES_PER_STEP)) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .anim_req   (anim_req),
    .anim_frame (anim_frame),
    .anim_done  (anim_done)
  );

  // Shadows only move at vblank so a frame is drawn with one consistent pose
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_sh     <= '0;
      sy_sh     <= '0;
      face_sh   <= 1'b0;
      player_sh <= 1'b0;
      frame_sh  <= 4'd0;
    end else if (frame_tick) begin
      sx_sh     <= sprite_x;
      sy_sh     <= sprite_y;
      face_sh   <= facing_left;
      player_sh <= player_in;
      frame_sh  <= anim_frame;
    end
  end

  assign rom_player = player_sh;

  // Stage p0: box test and address. A borrow sets bit 10, which also fails
  // the range compare, so no separate sign test is needed.
  always_comb begin
    dx      = {1'b0, draw_x} - {1'b0, sx_sh};
    dy      = {1'b0, draw_y} - {1'b0, sy_sh};
    hit_p0  = pixel_valid && (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));
    col_p0  = face_sh ? (5'(SPRITE_W - 1) - dx[4:0]) : dx[4:0];
    addr_p0 = hit_p0 ? (FRAME_BASE[frame_sh] + 14'(mul23(dy[4:0])) + 14'(col_p0)) : '0;
  end

  // Stage p1: address to ROM; stage p2: hit aligned with ROM rgb
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      hit_p1     <= 1'b0;
      sprite_hit <= 1'b0;
    end else begin
      rom_addr   <= addr_p0;
      hit_p1     <= hit_p0;
      sprite_hit <= hit_p1;
    end
  end

endmodule

// File: tb/tb_koopa_sprite_addr_gen.sv
// Bench for koopa_sprite_addr_gen: directed scenarios plus a randomized run
// against a behavioural model of the sprite box, ROM layout and animation rules.
module tb_koopa_sprite_addr_gen;
  localparam int FPS = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, pixel_valid, facing_left, player_in;
  logic [9:0]  draw_x, draw_y, sprite_x, sprite_y;
  logic [2:0]  anim_req;
  logic [13:0] rom_addr;
  logic        rom_player, sprite_hit, anim_done;
  logic [3:0]  anim_frame;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_state, m_frame, m_hold, m_done;
  int m_sx, m_sy, m_face, m_player, m_fsh;
  int exp_addr, exp_hit1, exp_hit;
  int first_f [5] = '{0, 2, 6, 8, 12};
  int last_f  [5] = '{1, 5, 7, 11, 13};

  koopa_sprite_addr_gen #(.SPRITE_W(23), .SPRITE_H(30), .FRAMES_PER_STEP(FPS)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pixel_valid(pixel_valid),
    .draw_x(draw_x), .draw_y(draw_y), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .facing_left(facing_left), .player_in(player_in), .anim_req(anim_req),
    .rom_addr(rom_addr), .rom_player(rom_player), .sprite_hit(sprite_hit),
    .anim_frame(anim_frame), .anim_done(anim_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_frame = 0; m_hold = 0; m_done = 0;
    m_sx = 0; m_sy = 0; m_face = 0; m_player = 0; m_fsh = 0;
    exp_addr = 0; exp_hit1 = 0; exp_hit = 0;
  endtask

  // One clock edge: advance DUT and model together, return 1ns after the edge
  task automatic step();
    int dx, dy, h, req, can;
    @(posedge clk);
    exp_hit = exp_hit1;
    dx = int'(draw_x) - m_sx;
    dy = int'(draw_y) - m_sy;
    h = (pixel_valid && dx >= 0 && dx < 23 && dy >= 0 && dy < 30) ? 1 : 0;
    exp_addr = h ? (m_fsh * 690 + dy * 23 + (m_face ? 22 - dx : dx)) : 0;
    exp_hit1 = h;
    if (frame_tick) begin
      m_sx = int'(sprite_x); m_sy = int'(sprite_y);
      m_face = int'(facing_left); m_player = int'(player_in); m_fsh = m_frame;
    end
    req = (anim_req > 3'd4) ? 0 : int'(anim_req);
    m_done = 0;
    can = (req != m_state) && (m_state <= 2 || (m_state == 3 && req == 4));
    if (can) begin
      m_state = req; m_frame = first_f[req]; m_hold = 0;
    end else if (frame_tick) begin
      if (m_hold < FPS - 1) m_hold++;
      else begin
        m_hold = 0;
        if (m_frame < last_f[m_state]) m_frame++;
        else if (m_state >= 3) begin m_state = 0; m_frame = 0; m_done = 1; end
        else if (m_state <= 1) m_frame = first_f[m_state];
      end
    end
    #1;
  endtask

  task automatic tick_step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_tick = 0; pixel_valid = 0; facing_left = 0; player_in = 0;
    draw_x = 0; draw_y = 0; sprite_x = 0; sprite_y = 0; anim_req = 0;
    model_reset();
    #1;
    checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
    checks++; if (sprite_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", sprite_hit); end
    checks++; if (anim_frame !== 4'd0) begin errors++; $display("FAIL reset_frame got %0d want 0", anim_frame); end
    checks++; if ({rom_player, anim_done} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {rom_player, anim_done}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_box_right();
    sprite_x = 100; sprite_y = 50; facing_left = 0; player_in = 1; anim_req = 0;
    tick_step();
    pixel_valid = 1; draw_x = 100; draw_y = 50; step();
    checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL t1_origin_addr got %0d want 0", rom_addr); end
    checks++; if (rom_player !== 1'b1) begin errors++; $display("FAIL t1_player got %b want 1", rom_player); end
    draw_x = 122; draw_y = 79; step();
    checks++; if (sprite_hit !== 1'b1) begin errors++; $display("FAIL t1_origin_hit got %b want 1", sprite_hit); end
    checks++; if (rom_addr !== 14'd689) begin errors++; $display("FAIL t1_corner_addr got %0d want 689", rom_addr); end
    draw_x = 123; step();
    checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL t1_outside_addr got %0d want 0", rom_addr); end
    step();
    checks++; if (sprite_hit !== 1'b0) begin errors++; $display("FAIL t1_outside_hit got %b want 0", sprite_hit); end
  endtask

  task automatic test_box_mirror();
    facing_left = 1; tick_step();
    draw_x = 100; draw_y = 50; step();
    checks++; if (rom_addr !== 14'd22) begin errors++; $display("FAIL t2_mirror_left got %0d want 22", rom_addr); end
    draw_x = 122; step();
    checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL t2_mirror_right got %0d want 0", rom_addr); end
    pixel_valid = 0; step();
    checks++; if (sprite_hit !== 1'b1) begin errors++; $display("FAIL t2_mirror_hit got %b want 1", sprite_hit); end
  endtask

  task automatic test_walk();
    int expf;
    facing_left = 0; anim_req = 1; step();
    checks++; if (anim_frame !== 4'd2) begin errors++; $display("FAIL t3_walk_start got %0d want 2", anim_frame); end
    expf = 2;
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < FPS; t++) begin
        tick_step();
        if (t < FPS - 1) begin
          checks++; if (anim_frame !== 4'(expf)) begin errors++; $display("FAIL t3_walk_hold got %0d want %0d", anim_frame, expf); end
        end
        if (expf == 3 && t == 0) begin pixel_valid = 1; draw_x = 100; draw_y = 50; end
        step();
        if (expf == 3 && t == 0) begin
          checks++; if (rom_addr !== 14'd2070) begin errors++; $display("FAIL t3_frame3_addr got %0d want 2070", rom_addr); end
          pixel_valid = 0;
        end
      end
      expf = (expf == 5) ? 2 : expf + 1;
      checks++; if (anim_frame !== 4'(expf)) begin errors++; $display("FAIL t3_walk_step got %0d want %0d", anim_frame, expf); end
    end
  endtask

  task automatic test_oneshot();
    anim_req = 3; step();
    checks++; if (anim_frame !== 4'd8) begin errors++; $display("FAIL t4_attack_start got %0d want 8", anim_frame); end
    anim_req = 1;
    for (int f = 8; f <= 11; f++) begin
      for (int t = 0; t < FPS; t++) begin
        if (f == 11 && t == FPS - 1) anim_req = 0;
        tick_step();
        if (t == FPS - 1) begin
          if (f < 11) begin
            checks++; if (anim_frame !== 4'(f + 1)) begin errors++; $display("FAIL t4_attack_step got %0d want %0d", anim_frame, f + 1); end
          end else begin
            checks++; if (anim_done !== 1'b1) begin errors++; $display("FAIL t4_done_pulse got %b want 1", anim_done); end
            checks++; if (anim_frame !== 4'd0) begin errors++; $display("FAIL t4_done_frame got %0d want 0", anim_frame); end
          end
        end
        step();
      end
    end
    checks++; if (anim_done !== 1'b0 || anim_frame !== 4'd0) begin errors++; $display("FAIL t4_after_done got done=%b frame=%0d want 0/0", anim_done, anim_frame); end
    anim_req = 3; step();
    for (int t = 0; t < FPS; t++) begin tick_step(); step(); end
    checks++; if (anim_frame !== 4'd9) begin errors++; $display("FAIL t4_attack9 got %0d want 9", anim_frame); end
    anim_req = 4; step();
    checks++; if (anim_frame !== 4'd12) begin errors++; $display("FAIL t4_hurt_preempt got %0d want 12", anim_frame); end
    anim_req = 3;
    for (int t = 0; t < FPS; t++) begin tick_step(); step(); end
    checks++; if (anim_frame !== 4'd13) begin errors++; $display("FAIL t4_hurt13 got %0d want 13", anim_frame); end
    anim_req = 0;
    for (int t = 0; t < FPS; t++) tick_step();
    checks++; if (anim_done !== 1'b1 || anim_frame !== 4'd0) begin errors++; $display("FAIL t4_hurt_done got done=%b frame=%0d want 1/0", anim_done, anim_frame); end
  endtask

  task automatic test_jump_clip();
    int want;
    anim_req = 2; step();
    checks++; if (anim_frame !== 4'd6) begin errors++; $display("FAIL t5_jump_start got %0d want 6", anim_frame); end
    for (int i = 1; i <= 30; i++) begin
      tick_step();
      want = (i < FPS) ? 6 : 7;
      checks++; if (anim_frame !== 4'(want)) begin errors++; $display("FAIL t5_jump_hold tick %0d got %0d want %0d", i, anim_frame, want); end
    end
    sprite_x = 630; sprite_y = 50; facing_left = 0; tick_step();
    pixel_valid = 1; draw_y = 55;
    for (int x = 620; x <= 639; x++) begin
      draw_x = 10'(x); step();
      want = (x >= 630) ? (4830 + 5 * 23 + x - 630) : 0;
      checks++; if (rom_addr !== 14'(want)) begin errors++; $display("FAIL t5_clip_addr x=%0d got %0d want %0d", x, rom_addr, want); end
      step();
      checks++; if (sprite_hit !== (x >= 630)) begin errors++; $display("FAIL t5_clip_hit x=%0d got %b want %b", x, sprite_hit, x >= 630); end
    end
  endtask

  task automatic test_async_reset();
    anim_req = 1; step();
    draw_x = 631; draw_y = 55; pixel_valid = 1; step(); step();
    checks++; if (sprite_hit !== 1'b1 || anim_frame !== 4'd2) begin errors++; $display("FAIL t6_pre_reset got hit=%b frame=%0d want 1/2", sprite_hit, anim_frame); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rom_addr, sprite_hit, rom_player, anim_done} !== 17'd0 || anim_frame !== 4'd0) begin
      errors++; $display("FAIL t6_async_reset got addr=%0d hit=%b pl=%b done=%b frame=%0d want all 0", rom_addr, sprite_hit, rom_player, anim_done, anim_frame);
    end
    model_reset();
    anim_req = 0; pixel_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    step(); step();
    checks++; if (anim_frame !== 4'd0 || sprite_hit !== 1'b0 || rom_player !== 1'b0) begin errors++; $display("FAIL t6_resume got frame=%0d hit=%b pl=%b want 0/0/0", anim_frame, sprite_hit, rom_player); end
  endtask

  task automatic test_random();
    int x, y;
    for (int i = 0; i < 1500; i++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) anim_req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        sprite_x = 10'($urandom_range(0, 639)); sprite_y = 10'($urandom_range(0, 479));
        facing_left = 1'($urandom_range(0, 1)); player_in = 1'($urandom_range(0, 1));
      end
      x = m_sx + $urandom_range(0, 30) - 4; y = m_sy + $urandom_range(0, 36) - 4;
      x = (x < 0) ? 0 : (x > 639 ? 639 : x);
      y = (y < 0) ? 0 : (y > 479 ? 479 : y);
      draw_x = 10'(x); draw_y = 10'(y);
      pixel_valid = ($urandom_range(0, 7) != 0);
      step();
      checks++; if (rom_addr !== 14'(exp_addr)) begin errors++; $display("FAIL rnd_addr cyc %0d got %0d want %0d", i, rom_addr, exp_addr); end
      checks++; if (sprite_hit !== 1'(exp_hit)) begin errors++; $display("FAIL rnd_hit cyc %0d got %b want %0d", i, sprite_hit, exp_hit); end
      checks++; if (anim_frame !== 4'(m_frame)) begin errors++; $display("FAIL rnd_frame cyc %0d got %0d want %0d", i, anim_frame, m_frame); end
      checks++; if (anim_done !== 1'(m_done)) begin errors++; $display("FAIL rnd_done cyc %0d got %b want %0d", i, anim_done, m_done); end
      checks++; if (rom_player !== 1'(m_player)) begin errors++; $display("FAIL rnd_player cyc %0d got %b want %0d", i, rom_player, m_player); end
    end
    frame_tick = 0;
  endtask

  initial begin
    test_reset();
    test_box_right();
    test_box_mirror();
    test_walk();
    test_oneshot();
    test_jump_clip();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
